// File: rtl/usb_cmd_sequencer.sv
// Host-command sequencer between the FT232H comm controller and the reservoir core.
// Decodes byte packets from the PC into run-config register writes and run
// start/abort strobes. Once a run completes, it asks the comm controller to
// upload the sample RAM.
module usb_cmd_sequencer #(
   parameter logic [15:0] GAIN_RST = 16'h0100,
   parameter logic [15:0] LEN_RST  = 16'd400,
   parameter int unsigned TIMEOUT  = 50_000_000,
   parameter int unsigned TO_W     = 26
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        usb_tx_active,
   input  logic        run_done,
   output logic        write_sig,
   output logic        run_start,
   output logic        run_abort,
   output logic [15:0] gain_reg,
   output logic [15:0] len_reg,
   output logic        busy,
   output logic        err_flag,
   output logic [2:0]  state_dbg
);

   localparam logic [7:0] OP_SET_GAIN = 8'hA1;
   localparam logic [7:0] OP_SET_LEN  = 8'hA2;
   localparam logic [7:0] OP_RUN      = 8'hA3;
   localparam logic [7:0] OP_UPLOAD   = 8'hA4;
   localparam logic [7:0] OP_ABORT    = 8'hA5;

   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      GET_HI   = 3'd1,
      GET_LO   = 3'd2,
      WAIT_RUN = 3'd3,
      UP_REQ   = 3'd4,
      UP_WAIT  = 3'd5
   } state_t;

   state_t          state_q, state_d;
   logic [TO_W-1:0] to_q, to_d;
   logic            sel_len_q, sel_len_d;   // target of the pending packet: 1 = len_reg
   logic [7:0]      hi_q, hi_d;
   logic [15:0]     gain_q, gain_d;
   logic [15:0]     len_q, len_d;
   logic            err_q, err_d;
   logic            start_q, start_d;
   logic            abort_q, abort_d;
   logic            wr_q;
   logic            busy_q;

   // Next-state, payload capture, timeout and strobe generation.
   always_comb begin
      state_d   = state_q;
      to_d      = '0;
      sel_len_d = sel_len_q;
      hi_d      = hi_q;
      gain_d    = gain_q;
      len_d     = len_q;
      err_d     = err_q;
      start_d   = 1'b0;
      abort_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (rx_valid) begin
               case (rx_data)
                  OP_SET_GAIN: begin
                     sel_len_d = 1'b0;
                     err_d     = 1'b0;
                     state_d   = GET_HI;
                  end
                  OP_SET_LEN: begin
                     sel_len_d = 1'b1;
                     err_d     = 1'b0;
                     state_d   = GET_HI;
                  end
                  OP_RUN: begin
                     start_d = 1'b1;
                     err_d   = 1'b0;
                     state_d = WAIT_RUN;
                  end
                  OP_UPLOAD: begin
                     err_d   = 1'b0;
                     state_d = UP_REQ;
                  end
                  OP_ABORT: begin
                     err_d = 1'b0;
                  end
                  default: begin
                     err_d = 1'b1;
                  end
               endcase
            end
         end

         GET_HI: begin
            if (rx_valid) begin
               hi_d    = rx_data;
               state_d = GET_LO;
            end else if (to_q == TO_MAX) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               to_d = to_q + 1'b1;
            end
         end

         GET_LO: begin
            // The target register is written only here, so an abandoned
            // packet never disturbs it.
            if (rx_valid) begin
               if (sel_len_q) begin
                  len_d = {hi_q, rx_data};
               end else begin
                  gain_d = {hi_q, rx_data};
               end
               state_d = IDLE;
            end else if (to_q == TO_MAX) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               to_d = to_q + 1'b1;
            end
         end

         WAIT_RUN: begin
            // Abort takes priority over a coincident run_done: no upload.
            if (rx_valid && (rx_data == OP_ABORT)) begin
               abort_d = 1'b1;
               err_d   = 1'b0;
               state_d = IDLE;
            end else if (run_done) begin
               state_d = UP_REQ;
            end
         end

         UP_REQ: begin
            if (usb_tx_active) begin
               state_d = UP_WAIT;
            end
         end

         UP_WAIT: begin
            if (!usb_tx_active) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, configuration registers and registered outputs.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         to_q      <= '0;
         sel_len_q <= 1'b0;
         hi_q      <= '0;
         gain_q    <= GAIN_RST;
         len_q     <= LEN_RST;
         err_q     <= 1'b0;
         start_q   <= 1'b0;
         abort_q   <= 1'b0;
         wr_q      <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         to_q      <= to_d;
         sel_len_q <= sel_len_d;
         hi_q      <= hi_d;
         gain_q    <= gain_d;
         len_q     <= len_d;
         err_q     <= err_d;
         start_q   <= start_d;
         abort_q   <= abort_d;
         // Derived from the next state so they line up with state_q.
         wr_q      <= (state_d == UP_REQ);
         busy_q    <= (state_d != IDLE);
      end
   end

   assign write_sig = wr_q;
   assign run_start = start_q;
   assign run_abort = abort_q;
   assign gain_reg  = gain_q;
   assign len_reg   = len_q;
   assign busy      = busy_q;
   assign err_flag  = err_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_usb_cmd_sequencer.sv
// Self-checking bench for usb_cmd_sequencer: directed scenarios followed by
// randomized packet-level transactions compared against a register-level model.
module tb_usb_cmd_sequencer;

   localparam int unsigned TO = 64;

   logic        CLOCK_50 = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        usb_tx_active;
   logic        run_done;
   logic        write_sig;
   logic        run_start;
   logic        run_abort;
   logic [15:0] gain_reg;
   logic [15:0] len_reg;
   logic        busy;
   logic        err_flag;
   logic [2:0]  state_dbg;

   int checks = 0;
   int errors = 0;

   // Reference model: the architecturally visible registers after each transaction.
   logic [15:0] m_gain;
   logic [15:0] m_len;
   logic        m_err;

   // Cycle counts of asserted strobes, sampled once per clock.
   int n_start = 0;
   int n_abort = 0;
   int n_wr    = 0;

   usb_cmd_sequencer #(
      .GAIN_RST(16'h0100),
      .LEN_RST (16'd400),
      .TIMEOUT (TO),
      .TO_W    (7)
   ) dut (
      .CLOCK_50     (CLOCK_50),
      .reset        (reset),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .usb_tx_active(usb_tx_active),
      .run_done     (run_done),
      .write_sig    (write_sig),
      .run_start    (run_start),
      .run_abort    (run_abort),
      .gain_reg     (gain_reg),
      .len_reg      (len_reg),
      .busy         (busy),
      .err_flag     (err_flag),
      .state_dbg    (state_dbg)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) begin
      if (run_start === 1'b1) n_start++;
      if (run_abort === 1'b1) n_abort++;
      if (write_sig === 1'b1) n_wr++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge CLOCK_50);
   endtask

   // Presents one byte for exactly one clock; returns at the following negedge.
   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge CLOCK_50);
      rx_valid = 1'b0;
      rx_data  = $urandom;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".gain"},  32'(gain_reg),  32'(m_gain));
      chk({tag, ".len"},   32'(len_reg),   32'(m_len));
      chk({tag, ".err"},   32'(err_flag),  32'(m_err));
      chk({tag, ".state"}, 32'(state_dbg), 32'd0);
      chk({tag, ".busy"},  32'(busy),      32'd0);
      chk({tag, ".wr"},    32'(write_sig), 32'd0);
   endtask

   task automatic do_set(input bit is_len, input logic [15:0] v);
      send(is_len ? 8'hA2 : 8'hA1);
      chk("set.state_hi", 32'(state_dbg), 32'd1);
      idle($urandom_range(0, 5));
      send(v[15:8]);
      chk("set.partial_gain", 32'(gain_reg), 32'(m_gain));
      chk("set.partial_len",  32'(len_reg),  32'(m_len));
      idle($urandom_range(0, 5));
      send(v[7:0]);
      if (is_len) m_len = v;
      else        m_gain = v;
      m_err = 1'b0;
   endtask

   task automatic do_bad();
      logic [7:0] b;
      b = 8'($urandom);
      if (b >= 8'hA1 && b <= 8'hA5) b = 8'h7F;
      send(b);
      m_err = 1'b1;
   endtask

   task automatic do_timeout(input bit is_len, input bit after_hi);
      send(is_len ? 8'hA2 : 8'hA1);
      if (after_hi) send(8'($urandom));
      idle(TO - 2);
      chk("to.pending", 32'(state_dbg), after_hi ? 32'd2 : 32'd1);
      chk("to.err_pending", 32'(err_flag), 32'd0);
      idle(4);
      m_err = 1'b1;
   endtask

   // Run to completion, with ignored noise bytes in WAIT_RUN and UP_WAIT.
   task automatic do_run_done();
      int s;
      logic [7:0] b;
      s = n_start;
      send(8'hA3);
      chk("run.start", 32'(run_start), 32'd1);
      chk("run.state", 32'(state_dbg), 32'd3);
      repeat ($urandom_range(1, 15)) begin
         if ($urandom_range(0, 3) == 0) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h00;
            send(b);
         end else begin
            idle(1);
         end
      end
      chk("run.busy", 32'(busy), 32'd1);
      run_done = 1'b1;
      @(negedge CLOCK_50);
      run_done = 1'b0;
      chk("run.wr_on", 32'(write_sig), 32'd1);
      idle($urandom_range(0, 5));
      chk("run.wr_held", 32'(write_sig), 32'd1);
      usb_tx_active = 1'b1;
      @(negedge CLOCK_50);
      chk("run.wr_off", 32'(write_sig), 32'd0);
      chk("run.upwait", 32'(state_dbg), 32'd5);
      repeat ($urandom_range(0, 20)) begin
         if ($urandom_range(0, 2) == 0) send(8'($urandom_range(8'hA1, 8'hA5)));
         else idle(1);
      end
      usb_tx_active = 1'b0;
      @(negedge CLOCK_50);
      idle(2);
      chk("run.start_count", 32'(n_start - s), 32'd1);
      m_err = 1'b0;
   endtask

   task automatic do_abort(input bit with_done);
      int w;
      int a;
      send(8'hA3);
      idle($urandom_range(0, 8));
      w = n_wr;
      a = n_abort;
      rx_data  = 8'hA5;
      rx_valid = 1'b1;
      run_done = with_done;
      @(negedge CLOCK_50);
      rx_valid = 1'b0;
      run_done = 1'b0;
      chk("abort.strobe", 32'(run_abort), 32'd1);
      chk("abort.state",  32'(state_dbg), 32'd0);
      idle(1);
      chk("abort.strobe_off", 32'(run_abort), 32'd0);
      idle(3);
      chk("abort.no_upload", 32'(n_wr - w), 32'd0);
      chk("abort.count", 32'(n_abort - a), 32'd1);
      m_err = 1'b0;
   endtask

   task automatic do_upload();
      send(8'hA4);
      chk("up.state", 32'(state_dbg), 32'd4);
      chk("up.wr",    32'(write_sig), 32'd1);
      idle($urandom_range(0, 4));
      usb_tx_active = 1'b1;
      @(negedge CLOCK_50);
      idle($urandom_range(0, 6));
      usb_tx_active = 1'b0;
      @(negedge CLOCK_50);
      m_err = 1'b0;
   endtask

   initial begin
      reset         = 1'b1;
      rx_data       = '0;
      rx_valid      = 1'b0;
      usb_tx_active = 1'b0;
      run_done      = 1'b0;
      m_gain        = 16'h0100;
      m_len         = 16'd400;
      m_err         = 1'b0;
      idle(3);
      check_model("reset");
      chk("reset.start", 32'(run_start), 32'd0);
      chk("reset.abort", 32'(run_abort), 32'd0);
      reset = 1'b0;
      idle(2);

      // Gain packet; len untouched.
      do_set(1'b0, 16'h1234);
      chk("t1.gain", 32'(gain_reg), 32'h1234);
      check_model("t1");

      // Length packet abandoned after the high byte, then upload clears the error.
      send(8'hA2);
      send(8'h01);
      idle(TO - 2);
      chk("t2.pending", 32'(state_dbg), 32'd2);
      idle(4);
      m_err = 1'b1;
      check_model("t2");
      chk("t2.len", 32'(len_reg), 32'd400);
      do_upload();
      check_model("t2.clear");

      // Run with automatic upload at fixed timing.
      send(8'hA3);
      chk("t3.start", 32'(run_start), 32'd1);
      idle(1);
      chk("t3.start_off", 32'(run_start), 32'd0);
      idle(8);
      run_done = 1'b1;
      @(negedge CLOCK_50);
      run_done = 1'b0;
      chk("t3.wr", 32'(write_sig), 32'd1);
      idle(2);
      usb_tx_active = 1'b1;
      @(negedge CLOCK_50);
      chk("t3.wr_off", 32'(write_sig), 32'd0);
      send(8'hA1);
      send(8'h55);
      send(8'h66);
      idle(196);
      chk("t3.busy_active", 32'(busy), 32'd1);
      usb_tx_active = 1'b0;
      @(negedge CLOCK_50);
      check_model("t3");

      // Abort coinciding with run_done.
      do_abort(1'b1);
      check_model("t4");

      // Unknown opcode in IDLE.
      send(8'h7F);
      m_err = 1'b1;
      check_model("t5");
      send(8'hA5);
      m_err = 1'b0;
      check_model("t5.clear");

      // Asynchronous reset in the middle of a gain packet.
      do_set(1'b0, 16'h1234);
      send(8'hA1);
      send(8'h12);
      chk("t6.getlo", 32'(state_dbg), 32'd2);
      #3 reset = 1'b1;
      #1;
      chk("t6.gain",  32'(gain_reg),  32'h0100);
      chk("t6.state", 32'(state_dbg), 32'd0);
      chk("t6.busy",  32'(busy),      32'd0);
      @(negedge CLOCK_50);
      reset  = 1'b0;
      m_gain = 16'h0100;
      m_len  = 16'd400;
      m_err  = 1'b0;
      idle(1);
      check_model("t6");

      // Randomized transaction mix.
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 7))
            0: do_set(1'b0, 16'($urandom));
            1: do_set(1'b1, 16'($urandom));
            2: do_bad();
            3: do_run_done();
            4: do_abort(1'($urandom));
            5: do_upload();
            6: do_timeout(1'($urandom), 1'($urandom));
            default: begin
               send(8'hA5);
               m_err = 1'b0;
            end
         endcase
         check_model("rand");
         idle($urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
